buffer_ptr_ctrl: RTL

- Pointer and flow controller for the shared multi-word circular buffer RAM: PAR_WRITE words written per beat, PAR_READ words read combinationally from a start address.
- Sits between the upstream producer (valid/ready) and the downstream window consumer (valid/ready).
- Generates write_en/write_addr and read_en/read_addr, and tracks occupancy.
- Supports a sliding-window read: each accepted window pops STRIDE words.
- Handles frame end by draining the buffer, then discarding the leftover tail.

---
 rtl/buffer_pkg.sv | 34 +++
 rtl/buffer_ptr_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/buffer_pkg.sv
// Shared definitions for the circular-buffer pointer controller: the frame
// state encoding, the buffer depth derived from the address width, and the
// parameter legality check evaluated at elaboration.
package buffer_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } buf_state_e;

    localparam int unsigned DEFAULT_BUFFER_ADDR = 32'd3;

    // Number of words addressed by an address of the given width.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    localparam int unsigned DEFAULT_DEPTH = depth_of(DEFAULT_BUFFER_ADDR);

    // A window must pop at least one word and no more than it shows, and
    // neither a write beat nor a window may exceed the whole buffer.
    function automatic bit params_legal(input int unsigned par_write,
                                        input int unsigned par_read,
                                        input int unsigned stride,
                                        input int unsigned addr_w);
        int unsigned depth_v;
        depth_v = depth_of(addr_w);
        return (par_write >= 32'd1) && (par_read >= 32'd1) &&
               (stride >= 32'd1) && (stride <= par_read) &&
               (par_write <= depth_v) && (par_read <= depth_v);
    endfunction

endpackage

// File: rtl/buffer_ptr_ctrl.sv
// Pointer and flow controller for the shared multi-word circular buffer.
// Producer beats push PAR_WRITE words; each accepted PAR_READ-word window
// pops STRIDE words, so overlapping window words stay counted until popped.
// A beat flagged wr_last drains the buffer, then the leftover tail (fewer
// words than a window) is discarded and frame_done pulses for one cycle.
module buffer_ptr_ctrl
    import buffer_pkg::*;
#(
    parameter int unsigned PAR_WRITE   = 32'd2,
    parameter int unsigned PAR_READ    = 32'd4,
    parameter int unsigned STRIDE      = 32'd1,
    parameter int unsigned BUFFER_ADDR = 32'd3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_valid,
    input  logic                   wr_last,
    output logic                   wr_ready,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic                   write_en,
    output logic [BUFFER_ADDR-1:0] write_addr,
    output logic                   read_en,
    output logic [BUFFER_ADDR-1:0] read_addr,
    output logic [BUFFER_ADDR:0]   count,
    output logic                   full,
    output logic                   empty,
    output logic                   frame_done
);

    localparam int unsigned DEPTH = depth_of(BUFFER_ADDR);
    localparam int unsigned CW    = BUFFER_ADDR + 32'd1;
    localparam int unsigned AW    = BUFFER_ADDR;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] PW_C    = CW'(PAR_WRITE);
    localparam logic [CW-1:0] PR_C    = CW'(PAR_READ);
    localparam logic [CW-1:0] ST_C    = CW'(STRIDE);
    localparam logic [AW-1:0] PW_A    = AW'(PAR_WRITE);
    localparam logic [AW-1:0] ST_A    = AW'(STRIDE);

    if (!params_legal(PAR_WRITE, PAR_READ, STRIDE, BUFFER_ADDR)) begin : g_param_error
        $error("buffer_ptr_ctrl: illegal PAR_WRITE/PAR_READ/STRIDE/BUFFER_ADDR combination");
    end

    buf_state_e      state_r;
    buf_state_e      state_next_s;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            frame_done_r;

    logic [CW-1:0]   free_s;
    logic [CW-1:0]   count_next_s;
    logic            wr_ready_s;
    logic            rd_valid_s;
    logic            push_s;
    logic            pop_s;
    logic            drain_done_s;

    // Handshake qualification from registered state; reset and flush mask every strobe.
    always_comb begin
        free_s     = DEPTH_C - count_r;
        wr_ready_s = 1'b0;
        rd_valid_s = 1'b0;
        if (rst || flush) begin
            wr_ready_s = 1'b0;
            rd_valid_s = 1'b0;
        end else begin
            wr_ready_s = (state_r == FILL) && (free_s >= PW_C);
            rd_valid_s = (count_r >= PR_C);
        end
        push_s = wr_valid && wr_ready_s;
        pop_s  = rd_valid_s && rd_ready;
    end

    // Occupancy after this cycle's push and pop, folded into one update.
    always_comb begin
        count_next_s = count_r;
        if (push_s) begin
            count_next_s = count_next_s + PW_C;
        end else begin
            count_next_s = count_next_s;
        end
        if (pop_s) begin
            count_next_s = count_next_s - ST_C;
        end else begin
            count_next_s = count_next_s;
        end
    end

    // Pointers and occupancy; flush and drain completion clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush || drain_done_s) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW_A;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ST_A;
            end
            count_r <= count_next_s;
        end
    end

    // Frame state: a wr_last push starts the drain, a sub-window tail ends it.
    always_comb begin
        state_next_s = state_r;
        drain_done_s = 1'b0;
        if (flush) begin
            state_next_s = FILL;
        end else begin
            case (state_r)
                FILL: begin
                    if (push_s && wr_last) begin
                        state_next_s = DRAIN;
                    end else begin
                        state_next_s = FILL;
                    end
                end
                DRAIN: begin
                    if (count_r < PR_C) begin
                        state_next_s = DONE;
                        drain_done_s = 1'b1;
                    end else begin
                        state_next_s = DRAIN;
                    end
                end
                DONE: begin
                    state_next_s = FILL;
                end
                default: begin
                    state_next_s = FILL;
                end
            endcase
        end
    end

    // State register; frame_done is high exactly for the cycle spent in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= FILL;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            frame_done_r <= drain_done_s;
        end
    end

    assign wr_ready   = wr_ready_s;
    assign rd_valid   = rd_valid_s;
    assign write_en   = push_s;
    assign write_addr = wr_ptr_r;
    assign read_en    = rd_valid_s;
    assign read_addr  = rd_ptr_r;
    assign count      = count_r;
    assign full       = (count_r == DEPTH_C);
    assign empty      = (count_r == {CW{1'b0}});
    assign frame_done = frame_done_r;

endmodule
